// File: rtl/alu_res_station.sv
// ALU reservation station: holds renamed instructions until both source operands
// are known (directly at dispatch or captured from the CDB), then presents the
// oldest ready instruction to the ALU as an alu_word.
//
// Handshakes: a transfer happens on the rising edge where valid && ready are both
// high. alloc_ready and issue_valid depend only on registered state, never on the
// partner's valid/ready. Once issue_valid is raised, the presented word stays
// stable until accepted, unless an older entry becomes ready and takes its place.
module alu_res_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        alloc_valid,
    output logic                        alloc_ready,
    input  logic [3:0]                  alloc_op,
    input  logic [2:0]                  alloc_funct3,
    input  logic                        alloc_funct7,
    input  logic [TAG_W-1:0]            alloc_src1_tag,
    input  logic [31:0]                 alloc_src1_data,
    input  logic                        alloc_src1_valid,
    input  logic [TAG_W-1:0]            alloc_src2_tag,
    input  logic [31:0]                 alloc_src2_data,
    input  logic                        alloc_src2_valid,
    input  logic [TAG_W-1:0]            alloc_rd_tag,
    input  logic [31:0]                 alloc_pc,
    input  logic                        cdb_valid,
    input  logic [TAG_W-1:0]            cdb_tag,
    input  logic [31:0]                 cdb_data,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [3:0]                  issue_op,
    output logic [2:0]                  issue_funct3,
    output logic                        issue_funct7,
    output logic [31:0]                 issue_src1_data,
    output logic [31:0]                 issue_src2_data,
    output logic [31:0]                 issue_pc,
    output logic [TAG_W-1:0]            issue_tag,
    output logic [$clog2(DEPTH):0]      occupancy
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic               busy;
        logic [3:0]         op;
        logic [2:0]         funct3;
        logic               funct7;
        logic [TAG_W-1:0]   s1_tag;
        logic [31:0]        s1_data;
        logic               s1_v;
        logic [TAG_W-1:0]   s2_tag;
        logic [31:0]        s2_data;
        logic               s2_v;
        logic [TAG_W-1:0]   rd_tag;
        logic [31:0]        pc;
        logic [IDX_W:0]     seq;
    } entry_t;

    entry_t             ent_q [DEPTH];
    logic [IDX_W:0]     seq_cnt_q;

    logic               alloc_fire;
    logic               issue_fire;
    logic [IDX_W-1:0]   alloc_idx;
    logic               free_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_any;
    logic [IDX_W:0]     best_age;
    logic [IDX_W:0]     age [DEPTH];
    logic [DEPTH-1:0]   rdy;
    logic               byp1;
    logic               byp2;

    // Lowest-index free entry; its existence is what alloc_ready reports.
    always_comb begin
        alloc_idx  = '0;
        free_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_q[i].busy && !free_found) begin
                alloc_idx  = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign alloc_ready = free_found;
    assign alloc_fire  = alloc_valid && alloc_ready;

    // Age of each entry relative to the allocation counter; wrap-safe because at
    // most DEPTH entries live while the counter spans 2*DEPTH values.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age[i] = seq_cnt_q - ent_q[i].seq;
            rdy[i] = ent_q[i].busy && ent_q[i].s1_v && ent_q[i].s2_v;
        end
    end

    // Oldest ready entry wins the issue slot.
    always_comb begin
        sel_any  = 1'b0;
        sel_idx  = '0;
        best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rdy[i] && (!sel_any || age[i] > best_age)) begin
                sel_any  = 1'b1;
                sel_idx  = IDX_W'(i);
                best_age = age[i];
            end
        end
    end

    assign issue_valid = sel_any;
    assign issue_fire  = issue_valid && issue_ready;

    // Present the selected entry, or an all-zero word when nothing is ready.
    always_comb begin
        issue_op        = '0;
        issue_funct3    = '0;
        issue_funct7    = 1'b0;
        issue_src1_data = '0;
        issue_src2_data = '0;
        issue_pc        = '0;
        issue_tag       = '0;
        if (sel_any) begin
            issue_op        = ent_q[sel_idx].op;
            issue_funct3    = ent_q[sel_idx].funct3;
            issue_funct7    = ent_q[sel_idx].funct7;
            issue_src1_data = ent_q[sel_idx].s1_data;
            issue_src2_data = ent_q[sel_idx].s2_data;
            issue_pc        = ent_q[sel_idx].pc;
            issue_tag       = ent_q[sel_idx].rd_tag;
        end
    end

    // Number of busy entries.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + {{IDX_W{1'b0}}, ent_q[i].busy};
        end
    end

    // A broadcast in the dispatch cycle is captured directly so it is never lost.
    assign byp1 = !alloc_src1_valid && cdb_valid && (cdb_tag == alloc_src1_tag);
    assign byp2 = !alloc_src2_valid && cdb_valid && (cdb_tag == alloc_src2_tag);

    // Entry state: reset, flush, then allocation, CDB wakeup and issue release.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            seq_cnt_q <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i].busy <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].busy) begin
                    if (!ent_q[i].s1_v && cdb_valid && ent_q[i].s1_tag == cdb_tag) begin
                        ent_q[i].s1_v    <= 1'b1;
                        ent_q[i].s1_data <= cdb_data;
                    end
                    if (!ent_q[i].s2_v && cdb_valid && ent_q[i].s2_tag == cdb_tag) begin
                        ent_q[i].s2_v    <= 1'b1;
                        ent_q[i].s2_data <= cdb_data;
                    end
                    if (issue_fire && sel_idx == IDX_W'(i)) begin
                        ent_q[i].busy <= 1'b0;
                    end
                end else if (alloc_fire && alloc_idx == IDX_W'(i)) begin
                    ent_q[i].busy    <= 1'b1;
                    ent_q[i].op      <= alloc_op;
                    ent_q[i].funct3  <= alloc_funct3;
                    ent_q[i].funct7  <= alloc_funct7;
                    ent_q[i].s1_tag  <= alloc_src1_tag;
                    ent_q[i].s1_v    <= alloc_src1_valid || byp1;
                    ent_q[i].s1_data <= byp1 ? cdb_data : alloc_src1_data;
                    ent_q[i].s2_tag  <= alloc_src2_tag;
                    ent_q[i].s2_v    <= alloc_src2_valid || byp2;
                    ent_q[i].s2_data <= byp2 ? cdb_data : alloc_src2_data;
                    ent_q[i].rd_tag  <= alloc_rd_tag;
                    ent_q[i].pc      <= alloc_pc;
                    ent_q[i].seq     <= seq_cnt_q;
                end
            end
            if (alloc_fire) begin
                seq_cnt_q <= seq_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_res_station.sv
// Directed bench for alu_res_station: inputs are driven and outputs checked at
// the falling edge, half a cycle away from the state-updating rising edge.
module tb_alu_res_station;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [3:0]  alloc_op;
  logic [2:0]  alloc_funct3;
  logic        alloc_funct7;
  logic [2:0]  alloc_src1_tag;
  logic [31:0] alloc_src1_data;
  logic        alloc_src1_valid;
  logic [2:0]  alloc_src2_tag;
  logic [31:0] alloc_src2_data;
  logic        alloc_src2_valid;
  logic [2:0]  alloc_rd_tag;
  logic [31:0] alloc_pc;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [2:0]  issue_funct3;
  logic        issue_funct7;
  logic [31:0] issue_src1_data;
  logic [31:0] issue_src2_data;
  logic [31:0] issue_pc;
  logic [2:0]  issue_tag;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  alu_res_station #(.DEPTH(4), .TAG_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_funct3(alloc_funct3), .alloc_funct7(alloc_funct7),
    .alloc_src1_tag(alloc_src1_tag), .alloc_src1_data(alloc_src1_data),
    .alloc_src1_valid(alloc_src1_valid),
    .alloc_src2_tag(alloc_src2_tag), .alloc_src2_data(alloc_src2_data),
    .alloc_src2_valid(alloc_src2_valid),
    .alloc_rd_tag(alloc_rd_tag), .alloc_pc(alloc_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
    .issue_src1_data(issue_src1_data), .issue_src2_data(issue_src2_data),
    .issue_pc(issue_pc), .issue_tag(issue_tag), .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one instruction for a single cycle.
  task automatic do_alloc(input logic [3:0] op, input logic s1v, input logic [2:0] s1t,
                          input logic [31:0] s1d, input logic s2v, input logic [2:0] s2t,
                          input logic [31:0] s2d, input logic [2:0] rd, input logic [31:0] pc);
    alloc_valid      = 1'b1;
    alloc_op         = op;
    alloc_src1_valid = s1v;
    alloc_src1_tag   = s1t;
    alloc_src1_data  = s1d;
    alloc_src2_valid = s2v;
    alloc_src2_tag   = s2t;
    alloc_src2_data  = s2d;
    alloc_rd_tag     = rd;
    alloc_pc         = pc;
    tick();
    alloc_valid      = 1'b0;
  endtask

  task automatic issue_expect_queue(input string tag);
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      issue_ready = 1'b1;
      check({tag, "_valid"}, {31'd0, issue_valid}, 32'd1);
      check({tag, "_tag"}, {29'd0, issue_tag}, e);
      tick();
    end
    issue_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_op = '0; alloc_funct3 = '0;
    alloc_funct7 = 1'b0; alloc_src1_tag = '0; alloc_src1_data = '0; alloc_src1_valid = 1'b0;
    alloc_src2_tag = '0; alloc_src2_data = '0; alloc_src2_valid = 1'b0; alloc_rd_tag = '0;
    alloc_pc = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // reset state
    check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    check("rst_alloc_ready", {31'd0, alloc_ready}, 32'd1);
    check("rst_occupancy", {29'd0, occupancy}, 32'd0);
    check("rst_src1", issue_src1_data, 32'd0);

    // 1: both sources ready -> issuable next cycle
    alloc_funct3 = 3'b101; alloc_funct7 = 1'b1;
    do_alloc(4'd1, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd7, 3'd2, 32'h100);
    alloc_funct3 = 3'b000; alloc_funct7 = 1'b0;
    check("t1_valid", {31'd0, issue_valid}, 32'd1);
    check("t1_op", {28'd0, issue_op}, 32'd1);
    check("t1_src1", issue_src1_data, 32'd5);
    check("t1_src2", issue_src2_data, 32'd7);
    check("t1_tag", {29'd0, issue_tag}, 32'd2);
    check("t1_f3", {29'd0, issue_funct3}, 32'd5);
    check("t1_f7", {31'd0, issue_funct7}, 32'd1);
    check("t1_pc", issue_pc, 32'h100);
    check("t1_occ", {29'd0, occupancy}, 32'd1);
    issue_ready = 1'b1; tick(); issue_ready = 1'b0;
    check("t1_occ_after", {29'd0, occupancy}, 32'd0);
    check("t1_valid_after", {31'd0, issue_valid}, 32'd0);

    // 2: wakeup via CDB
    do_alloc(4'd2, 1'b0, 3'd3, 32'd0, 1'b1, 3'd0, 32'd1, 3'd5, 32'h104);
    check("t2_wait", {31'd0, issue_valid}, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'h1234;
    tick();
    cdb_valid = 1'b0;
    check("t2_valid", {31'd0, issue_valid}, 32'd1);
    check("t2_src1", issue_src1_data, 32'h1234);
    check("t2_tag", {29'd0, issue_tag}, 32'd5);
    issue_ready = 1'b1; tick(); issue_ready = 1'b0;

    // 3: CDB broadcast in the allocation cycle is bypassed into the entry
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 32'd9;
    do_alloc(4'd3, 1'b1, 3'd0, 32'd3, 1'b0, 3'd4, 32'd0, 3'd6, 32'h108);
    cdb_valid = 1'b0;
    check("t3_valid", {31'd0, issue_valid}, 32'd1);
    check("t3_src2", issue_src2_data, 32'd9);
    check("t3_src1", issue_src1_data, 32'd3);
    issue_ready = 1'b1; tick(); issue_ready = 1'b0;
    check("t3_occ", {29'd0, occupancy}, 32'd0);

    // 4: fill, then alloc+issue on a full station
    for (int i = 0; i < 4; i++)
      do_alloc(4'd1, 1'b1, 3'd0, 32'(i), 1'b1, 3'd0, 32'd0, 3'(i), 32'h200);
    check("t4_full_ready", {31'd0, alloc_ready}, 32'd0);
    check("t4_full_occ", {29'd0, occupancy}, 32'd4);
    check("t4_oldest", {29'd0, issue_tag}, 32'd0);
    alloc_valid = 1'b1; alloc_rd_tag = 3'd7; issue_ready = 1'b1;
    check("t4_ready_same_cycle", {31'd0, alloc_ready}, 32'd0);
    tick();
    alloc_valid = 1'b0; issue_ready = 1'b0;
    check("t4_occ_after", {29'd0, occupancy}, 32'd3);
    check("t4_ready_after", {31'd0, alloc_ready}, 32'd1);
    exp_q.push_back(32'd1); exp_q.push_back(32'd2); exp_q.push_back(32'd3);
    issue_expect_queue("t4_drain");
    check("t4_empty", {29'd0, occupancy}, 32'd0);

    // 5: oldest-first even when the older entry sits at a higher index
    do_alloc(4'd1, 1'b1, 3'd0, 32'd0, 1'b1, 3'd0, 32'd0, 3'd4, 32'h300);  // X, index 0
    do_alloc(4'd1, 1'b0, 3'd5, 32'd0, 1'b1, 3'd0, 32'd0, 3'd1, 32'h304);  // A, index 1
    check("t5_x_tag", {29'd0, issue_tag}, 32'd4);
    issue_ready = 1'b1; tick(); issue_ready = 1'b0;
    do_alloc(4'd1, 1'b1, 3'd0, 32'd0, 1'b0, 3'd6, 32'd0, 3'd2, 32'h308);  // B, index 0
    check("t5_none_ready", {31'd0, issue_valid}, 32'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 32'h22;
    tick();
    check("t5_b_alone", {29'd0, issue_tag}, 32'd2);
    check("t5_b_src2", issue_src2_data, 32'h22);
    cdb_tag = 3'd5; cdb_data = 32'h11;
    tick();
    cdb_valid = 1'b0;
    check("t5_a_src1", issue_src1_data, 32'h11);
    exp_q.push_back(32'd1); exp_q.push_back(32'd2);
    issue_expect_queue("t5_order");
    check("t5_empty", {29'd0, occupancy}, 32'd0);

    // 6: flush beats alloc and wakeup
    do_alloc(4'd1, 1'b0, 3'd1, 32'd0, 1'b1, 3'd0, 32'd0, 3'd5, 32'h400);
    do_alloc(4'd1, 1'b0, 3'd2, 32'd0, 1'b1, 3'd0, 32'd0, 3'd6, 32'h404);
    do_alloc(4'd1, 1'b1, 3'd0, 32'd0, 1'b0, 3'd3, 32'd0, 3'd7, 32'h408);
    check("t6_occ3", {29'd0, occupancy}, 32'd3);
    flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'h55;
    do_alloc(4'd1, 1'b1, 3'd0, 32'd0, 1'b1, 3'd0, 32'd0, 3'd0, 32'h40c);
    flush = 1'b0; cdb_valid = 1'b0;
    check("t6_occ0", {29'd0, occupancy}, 32'd0);
    check("t6_no_issue", {31'd0, issue_valid}, 32'd0);
    check("t6_ready", {31'd0, alloc_ready}, 32'd1);
    for (int t = 2; t <= 3; t++) begin
      cdb_valid = 1'b1; cdb_tag = 3'(t); cdb_data = 32'h66;
      tick();
      cdb_valid = 1'b0;
      check("t6_stale_cdb", {31'd0, issue_valid}, 32'd0);
    end
    check("t6_occ_final", {29'd0, occupancy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
